hack_pc_fetch: RTL and testbench
================================

Name: hack_pc_fetch

Overview:
- Program-counter and instruction-fetch stage of the Hack CPU.
- Holds the 16-bit PC and drives the instruction ROM through a req/ack handshake.
- Presents each fetched instruction downstream with valid/ready.
- Consumes the A-register output as the jump target, and the ALU zr/ng flags plus jump bits to pick the next PC.

Parameters:
- WIDTH, 16, data/address width of PC and instruction word.
- RESET_ADDR, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- rom_req  output  1  fetch request to instruction ROM.
- rom_addr  output  WIDTH  fetch address; always equals pc_out.
- rom_ack  input  1  ROM has placed the word on rom_data this cycle.
- rom_data  input  WIDTH  instruction word from ROM.
- instr_out  output  WIDTH  registered fetched instruction.
- instr_valid  output  1  instr_out is valid.
- instr_ready  input  1  downstream accepts instr_out and supplies branch inputs this cycle.
- jump_en  input  1  current instruction is a C-instruction with jump semantics.
- jump_bits  input  3  Hack j1 j2 j3 = {lt, eq, gt}.
- zr  input  1  ALU result zero.
- ng  input  1  ALU result negative.
- a_in  input  WIDTH  A-register output; jump target.
- pc_out  output  WIDTH  current PC.

Behaviour:
- Reset is decided: one clock `clk`; reset is synchronous and active-low (`reset_n`).
  - `reset_n`=0 at a rising edge sets pc_out=RESET_ADDR, rom_req=0, instr_valid=0, instr_out=0, state=RST.
  - Reset wins over every simultaneous event.
- States:
  - RST: rom_req=0. Unconditionally go to FETCH on the next edge.
  - FETCH: rom_req=1, rom_addr=pc_out.
    - On rom_ack=1: instr_out<=rom_data, instr_valid<=1, go to HOLD. rom_req is 0 from the next cycle.
    - rom_ack=0: stay. Wait indefinitely; no timeout.
  - HOLD: instr_valid=1, instr_out stable, rom_req=0.
    - On instr_ready=1: instr_valid<=0, pc_out<=next_pc, go to FETCH.
    - instr_ready=0: hold everything.
- Branch condition: take = jump_en & ((j1&ng) | (j2&zr) | (j3&~ng&~zr)).
  - next_pc = take ? a_in : pc_out+1.
  - The increment is modulo 2^WIDTH, so 16'hFFFF wraps to 16'h0000.
- jump_en, jump_bits, zr, ng and a_in are sampled only on the HOLD & instr_ready edge and ignored otherwise.
- rom_ack is ignored outside FETCH. instr_ready is ignored outside HOLD.
- Throughput and latency:
  - Best case is 2 cycles per instruction: ack in the first FETCH cycle, ready in the first HOLD cycle.
  - instr_valid rises 1 cycle after the ack edge.
  - The new rom_addr is visible 1 cycle after the ready edge.
- Reset mid-FETCH or mid-HOLD discards the in-flight word. The next fetch is from RESET_ADDR.
- Outputs come from registers only, except rom_addr, which is a direct copy of pc_out. There is no combinational path from inputs to outputs.

Decomposition:
- Package hack_pkg:
  - WORD_W=16.
  - fetch_state_t enum {RST, FETCH, HOLD}.
  - Jump bit index constants J_LT=2, J_EQ=1, J_GT=0.
- Sub-module hack_jump_cond: combinational; inputs jump_en, jump_bits, zr, ng; output take. It is reused by the CPU control block.
- The PC and instr_out storage reuse the team's 16-bit load-enabled register.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles, release → pc_out=0, instr_valid=0, rom_req=1 with rom_addr=0 on the cycle after RST.
- Sequential fetch: ack same cycle with rom_data=16'h0005, ready=1, jump_en=0 → instr_out=0005 captured, pc_out=0001, and the next rom_addr=0001 two cycles after the first request.
- Taken JEQ: jump_bits=3'b010, zr=1, ng=0, jump_en=1, a_in=16'h0123 on the ready edge → pc_out=0123.
- Not taken JLT and unconditional JMP:
  - jump_bits=3'b100, ng=0, zr=0 → pc_out=pc+1.
  - jump_bits=3'b111 with any flags → pc_out=a_in.
- Wrap and stalls:
  - With pc=16'hFFFF and no jump → pc_out=0000.
  - rom_ack delayed 3 cycles → rom_req stays 1 and rom_addr stays stable throughout.
  - instr_ready low 4 cycles → instr_out stays stable.
- Reset mid-HOLD: pc=0042 with instr_valid=1, then reset_n=0 for 1 cycle → instr_valid=0, pc_out=0000, and the held word is never accepted.

Source files
------------

// File: rtl/hack_pkg.sv
// hack_pkg: shared word width, fetch states and jump bit positions for the Hack CPU
package hack_pkg;
  localparam int WORD_W = 16;
  localparam int J_LT = 2;
  localparam int J_EQ = 1;
  localparam int J_GT = 0;
  typedef enum logic [1:0] {RST, FETCH, HOLD} fetch_state_t;
endpackage

// File: rtl/hack_jump_cond.sv
// hack_jump_cond: decides whether a C-instruction jump is taken from j1 j2 j3 and ALU flags
module hack_jump_cond import hack_pkg::*; (
  input  logic       jump_en,
  input  logic [2:0] jump_bits,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);
  assign take = jump_en & ((jump_bits[J_LT] & ng) | (jump_bits[J_EQ] & zr) |
                           (jump_bits[J_GT] & ~ng & ~zr));
endmodule

// File: rtl/hack_reg.sv
// hack_reg: load-enabled register with synchronous active-low reset to INIT
module hack_reg #(
  parameter int W = 16,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (!reset_n) q <= INIT;
    else if (ld) q <= d;
endmodule

// File: rtl/hack_pc_fetch.sv
// hack_pc_fetch: Hack PC and instruction fetch stage, ROM req/ack in, valid/ready out
module hack_pc_fetch import hack_pkg::*; #(
  parameter int WIDTH = WORD_W,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             rom_req,
  output logic [WIDTH-1:0] rom_addr,
  input  logic             rom_ack,
  input  logic [WIDTH-1:0] rom_data,
  output logic [WIDTH-1:0] instr_out,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             jump_en,
  input  logic [2:0]       jump_bits,
  input  logic             zr,
  input  logic             ng,
  input  logic [WIDTH-1:0] a_in,
  output logic [WIDTH-1:0] pc_out
);
  fetch_state_t state;
  logic take, pc_ld, ir_ld;
  logic [WIDTH-1:0] next_pc;
  assign ir_ld = state == FETCH && rom_ack;
  assign pc_ld = state == HOLD && instr_ready;
  assign next_pc = take ? a_in : pc_out + WIDTH'(1);
  assign rom_addr = pc_out;
  hack_jump_cond u_cond (
    .jump_en(jump_en), .jump_bits(jump_bits), .zr(zr), .ng(ng), .take(take)
  );
  hack_reg #(.W(WIDTH), .INIT(RESET_ADDR)) u_pc (
    .clk(clk), .reset_n(reset_n), .ld(pc_ld), .d(next_pc), .q(pc_out)
  );
  hack_reg #(.W(WIDTH), .INIT('0)) u_ir (
    .clk(clk), .reset_n(reset_n), .ld(ir_ld), .d(rom_data), .q(instr_out)
  );
  // rom_req and instr_valid are registered copies of the next state's membership
  always_ff @(posedge clk)
    if (!reset_n) begin
      state       <= RST;
      rom_req     <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state == RST   ? FETCH :
                     state == FETCH ? (rom_ack ? HOLD : FETCH) :
                     state == HOLD  ? (instr_ready ? FETCH : HOLD) : RST;
      rom_req     <= state == RST || pc_ld || (state == FETCH && !rom_ack);
      instr_valid <= ir_ld || (state == HOLD && !instr_ready);
    end
endmodule

// File: tb/tb_hack_pc_fetch.sv
// tb_hack_pc_fetch: directed checks of reset, fetch handshake, branch selection, wrap and stalls
module tb_hack_pc_fetch;
  logic clk = 0, reset_n = 0;
  logic rom_req, rom_ack = 0, instr_valid, instr_ready = 0;
  logic jump_en = 0, zr = 0, ng = 0;
  logic [2:0] jump_bits = 0;
  logic [15:0] rom_addr, rom_data = 0, instr_out, a_in = 0, pc_out;
  int checks = 0, errors = 0;

  hack_pc_fetch dut (
    .clk(clk), .reset_n(reset_n), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_ack(rom_ack), .rom_data(rom_data), .instr_out(instr_out),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .jump_en(jump_en),
    .jump_bits(jump_bits), .zr(zr), .ng(ng), .a_in(a_in), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_fetch(input logic [15:0] data, input int delay, input logic [15:0] addr);
    for (int i = 0; i < delay; i++) begin
      rom_ack = 0;
      instr_ready = 1;
      tick();
      check("wait_req", 16'(rom_req), 16'h1);
      check("wait_addr", rom_addr, addr);
      check("wait_valid", 16'(instr_valid), 16'h0);
    end
    instr_ready = 0;
    rom_ack = 1;
    rom_data = data;
    tick();
    rom_ack = 0;
    rom_data = 16'hBEEF;
    check("cap_instr", instr_out, data);
    check("cap_valid", 16'(instr_valid), 16'h1);
    check("cap_req", 16'(rom_req), 16'h0);
  endtask

  task automatic do_accept(input logic je, input logic [2:0] jb, input logic z, input logic n,
                           input logic [15:0] a, input logic [15:0] exp_pc);
    jump_en = je; jump_bits = jb; zr = z; ng = n; a_in = a;
    instr_ready = 1;
    tick();
    instr_ready = 0;
    jump_en = 1; jump_bits = 3'b111; a_in = 16'hDEAD;
    check("acc_pc", pc_out, exp_pc);
    check("acc_addr", rom_addr, exp_pc);
    check("acc_valid", 16'(instr_valid), 16'h0);
    check("acc_req", 16'(rom_req), 16'h1);
  endtask

  initial begin
    tick();
    tick();
    check("rst_pc", pc_out, 16'h0000);
    check("rst_valid", 16'(instr_valid), 16'h0);
    check("rst_req", 16'(rom_req), 16'h0);
    check("rst_instr", instr_out, 16'h0000);
    reset_n = 1;
    tick();
    check("rel_req", 16'(rom_req), 16'h1);
    check("rel_addr", rom_addr, 16'h0000);
    do_fetch(16'h0005, 0, 16'h0000);
    do_accept(0, 3'b000, 0, 0, 16'h0777, 16'h0001);
    do_fetch(16'hEC12, 0, 16'h0001);
    do_accept(1, 3'b010, 1, 0, 16'h0123, 16'h0123);
    do_fetch(16'hE304, 0, 16'h0123);
    do_accept(1, 3'b100, 0, 0, 16'h0777, 16'h0124);
    do_fetch(16'hE307, 0, 16'h0124);
    do_accept(1, 3'b111, 0, 1, 16'hFFFF, 16'hFFFF);
    do_fetch(16'h1234, 3, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      rom_ack = 1;
      rom_data = 16'h5555;
      tick();
      check("stall_instr", instr_out, 16'h1234);
      check("stall_valid", 16'(instr_valid), 16'h1);
      check("stall_pc", pc_out, 16'hFFFF);
    end
    rom_ack = 0;
    do_accept(0, 3'b000, 0, 0, 16'h0999, 16'h0000);
    do_fetch(16'hE307, 0, 16'h0000);
    do_accept(0, 3'b111, 1, 1, 16'h0999, 16'h0001);
    do_fetch(16'hE301, 0, 16'h0001);
    do_accept(1, 3'b001, 0, 0, 16'h0042, 16'h0042);
    do_fetch(16'hE301, 0, 16'h0042);
    do_accept(1, 3'b001, 1, 0, 16'h0300, 16'h0043);
    do_accept(1, 3'b100, 0, 1, 16'h0042, 16'h0043);
    do_fetch(16'h0BAD, 0, 16'h0043);
    do_accept(1, 3'b100, 0, 1, 16'h0042, 16'h0042);
    do_fetch(16'h0BAD, 0, 16'h0042);
    reset_n = 0;
    instr_ready = 1;
    jump_en = 0;
    tick();
    reset_n = 1;
    instr_ready = 0;
    check("mid_valid", 16'(instr_valid), 16'h0);
    check("mid_pc", pc_out, 16'h0000);
    check("mid_instr", instr_out, 16'h0000);
    check("mid_req", 16'(rom_req), 16'h0);
    tick();
    check("mid_refetch_req", 16'(rom_req), 16'h1);
    check("mid_refetch_addr", rom_addr, 16'h0000);
    do_fetch(16'h0001, 0, 16'h0000);
    do_accept(0, 3'b000, 0, 0, 16'h0000, 16'h0001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
